ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch unit; the producer end of the instruction interface that the decode unit consumes.
- Owns the architectural PC and issues 32-bit read requests to instruction memory over a valid/ready request channel with a response channel.
- Presents {inst, pc, snpc} to decode under a valid/ready handshake.
- Fetches the next instruction only after the core returns dnpc.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address.
XLEN, 32, PC/instruction/data width; only 32 is supported.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
dnpc_valid  input  1  next-PC from execute/writeback is valid this cycle.
dnpc  input  32  next PC value.
mem_req_valid  output  1  fetch request valid.
mem_req_ready  input  1  memory accepts the request.
mem_req_addr  output  32  fetch address; word aligned.
mem_resp_valid  input  1  read data valid.
mem_resp_data  input  32  instruction word.
mem_resp_err  input  1  access fault on this response.
inst_valid  output  1  instruction available to decode.
inst_ready  input  1  decode accepts the instruction.
inst  output  32  fetched instruction word.
pc  output  32  PC of inst.
snpc  output  32  pc + 4, combinational, modulo 2^32.
fetch_err  output  1  inst is invalid (misaligned PC or access fault).
fetch_cnt  output  32  count of instructions handed to decode; wraps.
busy  output  1  high in S_REQ and S_WAIT.

Behaviour:
- Reset (rst high at a clock edge) sets:
  - state = S_REQ, pc = RESET_PC, inst = 0, fetch_err = 0, fetch_cnt = 0.
  - While rst is high, all outputs are forced to their reset values: mem_req_valid = 0, inst_valid = 0, busy = 0.
  - The first request is issued in the first cycle after rst falls.
- States: S_REQ, S_WAIT, S_HOLD, S_NEXT.
- S_REQ:
  - Outputs: mem_req_valid = 1, mem_req_addr = pc.
  - Address and valid stay stable until accepted.
  - On mem_req_ready -> S_WAIT.
  - If pc[1:0] != 0: no request is issued (mem_req_valid = 0). Next cycle: inst = 0, fetch_err = 1, -> S_HOLD.
- S_WAIT:
  - On mem_resp_valid: inst <= mem_resp_data, fetch_err <= mem_resp_err, -> S_HOLD.
  - On an access fault, inst <= 0.
  - The earliest response is the cycle after request acceptance, so minimum fetch latency is 2 cycles from S_REQ to inst_valid.
- S_HOLD:
  - inst_valid = 1; inst, pc and fetch_err are held stable until the handshake.
  - On inst_valid & inst_ready: fetch_cnt <= fetch_cnt + 1 (wraps at 2^32).
    - If dnpc_valid is also high in that cycle: pc <= dnpc, -> S_REQ.
    - Otherwise -> S_NEXT.
- S_NEXT:
  - Waits for dnpc_valid; then pc <= dnpc, -> S_REQ.
  - pc keeps the old value until then, so snpc stays consistent for jal/jalr writeback.
- Ignored inputs:
  - dnpc_valid in S_REQ, S_WAIT, and S_HOLD without a handshake.
  - mem_resp_valid outside S_WAIT; the response is dropped.
  - mem_req_ready outside S_REQ.
- Reset mid-operation: any state returns to S_REQ at RESET_PC. A response that arrives after reset is dropped by the S_WAIT rule above.
- At most one outstanding request at any time.
- busy = (state == S_REQ) | (state == S_WAIT).

Test Plan:
1. Reset, then zero-wait memory (ready = 1; resp one cycle after accept; data 32'h00100093):
   - Required: mem_req_addr = 32'h8000_0000 in cycle 1 after reset; inst_valid in cycle 3; inst = 32'h00100093; pc = 32'h8000_0000; snpc = 32'h8000_0004.
   - Then inst_ready = 1 and dnpc_valid = 1 with dnpc = 32'h8000_0004 in the same cycle: next request addr = 32'h8000_0004; fetch_cnt = 1.
2. Back-pressure: mem_req_ready low for 3 cycles, then inst_ready low for 4 cycles:
   - Required: mem_req_addr stable throughout; inst/pc stable; exactly one request; fetch_cnt increments once.
3. Late dnpc: handshake completes, dnpc_valid arrives 5 cycles later with 32'h8000_0100:
   - Required: no request during the gap; busy = 0 in S_NEXT; next mem_req_addr = 32'h8000_0100.
4. Faults:
   - mem_resp_err = 1 -> inst = 0, fetch_err = 1.
   - dnpc = 32'h8000_0102 -> no mem_req_valid; inst_valid next cycle with fetch_err = 1 and pc = 32'h8000_0102.
5. Reset mid-fetch: assert rst in S_WAIT; memory responds the cycle after:
   - Required: the response is dropped; a new request is issued to 32'h8000_0000; fetch_cnt = 0.
6. Wrap: pc = 32'hFFFF_FFFC -> snpc = 32'h0000_0000. Force fetch_cnt to 32'hFFFF_FFFF, complete one handshake -> fetch_cnt = 0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC and issues one read at a time. The instruction reaches decode 2+ cycles after the request phase starts.
// Request address and valid hold until accepted. inst, pc and fetch_err hold until decode accepts. No new fetch starts until dnpc arrives.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dnpc_valid,
  input  logic [XLEN-1:0] dnpc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  output logic            fetch_err,
  output logic [XLEN-1:0] fetch_cnt,
  output logic            busy
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_NEXT} state_t;

  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0] ONE        = XLEN'(1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            fetch_err_q, fetch_err_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            misaligned;

  assign misaligned = |pc_q[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      S_REQ: begin
        // A misaligned PC never reaches memory; it becomes a faulting instruction.
        if (misaligned) begin
          inst_d      = '0;
          fetch_err_d = 1'b1;
          state_d     = S_HOLD;
        end else if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          inst_d      = mem_resp_err ? '0 : mem_resp_data;
          fetch_err_d = mem_resp_err;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          fetch_cnt_d = fetch_cnt_q + ONE;
          if (dnpc_valid) begin
            pc_d    = dnpc;
            state_d = S_REQ;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        // pc stays on the retired instruction so snpc remains valid for link writeback.
        if (dnpc_valid) begin
          pc_d    = dnpc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Handshake outputs are gated by rst so nothing is offered while reset is held.
  assign mem_req_valid = ~rst & (state_q == S_REQ) & ~misaligned;
  assign mem_req_addr  = pc_q;
  assign inst_valid    = ~rst & (state_q == S_HOLD);
  assign busy          = ~rst & ((state_q == S_REQ) | (state_q == S_WAIT));
  assign inst          = inst_q;
  assign pc            = pc_q;
  assign snpc          = pc_q + INST_BYTES;
  assign fetch_err     = fetch_err_q;
  assign fetch_cnt     = fetch_cnt_q;

endmodule
